rcb_spi_regfile: RTL and testbench

//  Register bank directly downstream of the SPI slave. Decodes the slave's latched address and write/read strobes.

---
 rtl/rcb_spi_regfile_pkg.sv | 27 ++
 rtl/rcb_spi_regfile_edge_sync.sv | 18 +
 rtl/rcb_spi_regfile.sv | 128 ++++++++++++
 tb/tb_rcb_spi_regfile.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rcb_spi_regfile_pkg.sv
// Shared register map and helpers for the SPI-facing control/status register bank.
package rcb_spi_regfile_pkg;

  localparam logic [15:0] ADDR_VERSION    = 16'h0000;
  localparam logic [15:0] ADDR_SCRATCH    = 16'h0001;
  localparam logic [15:0] ADDR_STATUS     = 16'h0002;
  localparam logic [15:0] ADDR_EVENT      = 16'h0003;
  localparam logic [15:0] ADDR_EVENT_MASK = 16'h0004;
  localparam logic [15:0] ADDR_ERR_CNT    = 16'h0005;
  localparam logic [15:0] ADDR_TRANS_CNT  = 16'h0006;
  localparam logic [15:0] ADDR_CTRL       = 16'h0010;

  localparam logic [31:0] UNMAPPED_DEF = 32'hDEAD_BEEF;
  localparam int          EVT_W        = 8;

  // Fixed registers occupy 0..6; control words follow at ADDR_CTRL.
  function automatic logic is_mapped(input logic [15:0] a, input int nctrl);
    return (a <= ADDR_TRANS_CNT) || (a >= ADDR_CTRL && a < ADDR_CTRL + 16'(nctrl));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, v} + {15'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/rcb_spi_regfile_edge_sync.sv
// Two-flop synchronizer with a one-clock pulse on the synchronized rising edge.
module rcb_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [2:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh <= '0;
    else     sh <= {sh[1:0], din};
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/rcb_spi_regfile.sv
// Register bank behind the SPI slave: read snapshot pipeline, write decode,
// W1C event latch with mask/irq, error and transaction counters, control words.
module rcb_spi_regfile
  import rcb_spi_regfile_pkg::*;
#(
  parameter int          NUM_CTRL     = 8,
  parameter logic [31:0] VERSION      = 32'h0001_0000,
  parameter logic [31:0] UNMAPPED_VAL = UNMAPPED_DEF
) (
  input  logic                    clk_100m,
  input  logic                    rst_syn,
  input  logic [15:0]             addr,
  input  logic                    addr_rdy,
  input  logic [31:0]             data_mosi,
  input  logic                    data_mosi_rdy,
  input  logic                    data_miso_rdy,
  output logic [31:0]             data_miso,
  input  logic [31:0]             status_in,
  input  logic [EVT_W-1:0]        event_in,
  output logic [32*NUM_CTRL-1:0]  ctrl_out,
  output logic                    irq
);

  localparam int STAGES = 2;

  logic [STAGES:0]             vld_pipe;
  logic [STAGES:1]             vld_q;
  logic                        addr_rdy_d;
  logic [31:0]                 rd_word, rd_snap;
  logic [31:0]                 scratch, status_s1, status_s2;
  logic [EVT_W-1:0]            event_lat, event_mask, event_rise;
  logic [15:0]                 err_cnt, wr_cnt, rd_cnt;
  logic [NUM_CTRL-1:0][31:0]   ctrl_q;
  logic [NUM_CTRL-1:0]         wr_ctrl;
  logic                        wr_scratch, wr_event, wr_mask, wr_err, wr_unmapped, rd_unmapped;

  // Stage 0 is the addr_rdy edge; stage 1 muxes on the settled address; stage 2 drives MISO.
  assign vld_pipe = {vld_q, addr_rdy & ~addr_rdy_d};

  for (genvar i = 0; i < EVT_W; i++) begin : g_evt
    rcb_edge_sync u_sync (
      .clk  (clk_100m),
      .rst  (rst_syn),
      .din  (event_in[i]),
      .rise (event_rise[i])
    );
  end

  always_comb begin
    wr_scratch  = data_mosi_rdy && addr == ADDR_SCRATCH;
    wr_event    = data_mosi_rdy && addr == ADDR_EVENT;
    wr_mask     = data_mosi_rdy && addr == ADDR_EVENT_MASK;
    wr_err      = data_mosi_rdy && addr == ADDR_ERR_CNT;
    wr_unmapped = data_mosi_rdy && !is_mapped(addr, NUM_CTRL);
    for (int k = 0; k < NUM_CTRL; k++)
      wr_ctrl[k] = data_mosi_rdy && addr == ADDR_CTRL + 16'(k);
  end

  assign rd_unmapped = vld_pipe[1] && !is_mapped(addr, NUM_CTRL);

  always_comb begin
    rd_word = UNMAPPED_VAL;
    case (addr)
      ADDR_VERSION:    rd_word = VERSION;
      ADDR_SCRATCH:    rd_word = scratch;
      ADDR_STATUS:     rd_word = status_s2;
      ADDR_EVENT:      rd_word = {{(32-EVT_W){1'b0}}, event_lat};
      ADDR_EVENT_MASK: rd_word = {{(32-EVT_W){1'b0}}, event_mask};
      ADDR_ERR_CNT:    rd_word = {16'd0, err_cnt};
      ADDR_TRANS_CNT:  rd_word = {wr_cnt, rd_cnt};
      default:
        for (int k = 0; k < NUM_CTRL; k++)
          if (addr == ADDR_CTRL + 16'(k)) rd_word = ctrl_q[k];
    endcase
  end

  always_ff @(posedge clk_100m or posedge rst_syn) begin
    if (rst_syn) begin
      addr_rdy_d <= 1'b0;
      vld_q      <= '0;
      rd_snap    <= '0;
      data_miso  <= '0;
    end else begin
      addr_rdy_d <= addr_rdy;
      vld_q      <= vld_pipe[STAGES-1:0];
      if (vld_pipe[1]) rd_snap   <= rd_word;
      if (vld_pipe[2]) data_miso <= rd_snap;
    end
  end

  always_ff @(posedge clk_100m or posedge rst_syn) begin
    if (rst_syn) begin
      scratch    <= '0;
      status_s1  <= '0;
      status_s2  <= '0;
      event_lat  <= '0;
      event_mask <= '0;
      irq        <= 1'b0;
      ctrl_q     <= '0;
    end else begin
      status_s1 <= status_in;
      status_s2 <= status_s1;
      if (wr_scratch) scratch    <= data_mosi;
      if (wr_mask)    event_mask <= data_mosi[EVT_W-1:0];
      // OR-ing the new edges in last makes a coincident set beat the clear.
      event_lat <= (event_lat & ~(wr_event ? data_mosi[EVT_W-1:0] : '0)) | event_rise;
      irq       <= |(event_lat & event_mask);
      for (int k = 0; k < NUM_CTRL; k++)
        if (wr_ctrl[k]) ctrl_q[k] <= data_mosi;
    end
  end

  always_ff @(posedge clk_100m or posedge rst_syn) begin
    if (rst_syn) begin
      err_cnt <= '0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
    end else begin
      if (wr_err) err_cnt <= '0;
      else        err_cnt <= sat_inc(err_cnt, {1'b0, rd_unmapped} + {1'b0, wr_unmapped});
      if (data_mosi_rdy) wr_cnt <= wr_cnt + 16'd1;
      if (data_miso_rdy) rd_cnt <= rd_cnt + 16'd1;
    end
  end

  assign ctrl_out = ctrl_q;

endmodule

// File: tb/tb_rcb_spi_regfile.sv
// Scoreboard bench for rcb_spi_regfile: predicted read words are queued at address strobe
// and popped when data_miso is due.
module tb_rcb_spi_regfile;

  localparam int NC = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [15:0]        addr;
  logic               addr_rdy, data_mosi_rdy, data_miso_rdy, irq;
  logic [31:0]        data_mosi, data_miso, status_in;
  logic [7:0]         event_in;
  logic [32*NC-1:0]   ctrl_out;

  always #5 clk = ~clk;

  rcb_spi_regfile #(.NUM_CTRL(NC)) dut (
    .clk_100m      (clk),
    .rst_syn       (rst),
    .addr          (addr),
    .addr_rdy      (addr_rdy),
    .data_mosi     (data_mosi),
    .data_mosi_rdy (data_mosi_rdy),
    .data_miso_rdy (data_miso_rdy),
    .data_miso     (data_miso),
    .status_in     (status_in),
    .event_in      (event_in),
    .ctrl_out      (ctrl_out),
    .irq           (irq)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  logic [31:0] m_scratch, m_status;
  logic [7:0]  m_lat, m_mask;
  logic [15:0] m_err, m_wr, m_rd;
  logic [31:0] m_ctrl [NC];

  function automatic bit unmapped(input logic [15:0] a);
    return !(a <= 16'd6 || (a >= 16'h10 && a < 16'h10 + NC));
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] a);
    case (a)
      16'h0000: return 32'h0001_0000;
      16'h0001: return m_scratch;
      16'h0002: return m_status;
      16'h0003: return {24'd0, m_lat};
      16'h0004: return {24'd0, m_mask};
      16'h0005: return {16'd0, m_err};
      16'h0006: return {m_wr, m_rd};
      default:  return unmapped(a) ? 32'hDEAD_BEEF : m_ctrl[a - 16'h10];
    endcase
  endfunction

  function automatic logic [32*NC-1:0] model_ctrl();
    logic [32*NC-1:0] v;
    for (int k = 0; k < NC; k++) v[32*k +: 32] = m_ctrl[k];
    return v;
  endfunction

  task automatic model_reset();
    m_scratch = '0; m_lat = '0; m_mask = '0; m_err = '0; m_wr = '0; m_rd = '0;
    for (int k = 0; k < NC; k++) m_ctrl[k] = '0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; data_mosi = d; data_mosi_rdy = 1'b1;
    @(negedge clk);
    data_mosi_rdy = 1'b0;
    m_wr++;
    case (a)
      16'h0001: m_scratch = d;
      16'h0003: m_lat = m_lat & ~d[7:0];
      16'h0004: m_mask = d[7:0];
      16'h0005: m_err = '0;
      16'h0000, 16'h0002, 16'h0006: ;
      default:
        if (unmapped(a)) begin if (m_err != 16'hFFFF) m_err++; end
        else m_ctrl[a - 16'h10] = d;
    endcase
  endtask

  // Pushes the prediction at the strobe, returns the DUT word and the popped prediction.
  task automatic do_read(input logic [15:0] a, output logic [31:0] got, output logic [31:0] exp);
    @(negedge clk);
    addr = a; addr_rdy = 1'b1;
    exp_q.push_back(model_read(a));
    if (unmapped(a) && m_err != 16'hFFFF) m_err++;
    repeat (3) @(posedge clk);
    #1;
    got = data_miso;
    exp = exp_q.pop_front();
    addr_rdy = 1'b0;
    @(negedge clk);
    data_miso_rdy = 1'b1;
    @(negedge clk);
    data_miso_rdy = 1'b0;
    m_rd++;
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    rst = 1'b1; addr = '0; addr_rdy = 0; data_mosi = '0; data_mosi_rdy = 0;
    data_miso_rdy = 0; status_in = '0; event_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (data_miso !== 32'd0) begin n_err++; $display("FAIL reset_miso: got %h want 0", data_miso); end
    n_chk++; if (ctrl_out !== '0) begin n_err++; $display("FAIL reset_ctrl: got %h want 0", ctrl_out); end
    n_chk++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    rst = 1'b0;
    do_read(16'h0000, got, exp);
    n_chk++; if (got !== exp) begin n_err++; $display("FAIL version: got %h want %h", got, exp); end
    do_read(16'h0005, got, exp);
    n_chk++; if (got !== exp) begin n_err++; $display("FAIL err_after_reset: got %h want %h", got, exp); end
  endtask

  task automatic test_scratch_status();
    logic [31:0] got, exp;
    do_write(16'h0001, 32'hA5A5_5A5A);
    do_read(16'h0001, got, exp);
    n_chk++; if (got !== exp) begin n_err++; $display("FAIL scratch: got %h want %h", got, exp); end
    do_read(16'h0006, got, exp);
    n_chk++; if (got !== exp) begin n_err++; $display("FAIL trans_cnt: got %h want %h", got, exp); end
    status_in = 32'hC0FF_EE01;
    repeat (3) @(negedge clk);
    m_status = 32'hC0FF_EE01;
    do_read(16'h0002, got, exp);
    n_chk++; if (got !== exp) begin n_err++; $display("FAIL status: got %h want %h", got, exp); end
  endtask

  task automatic test_event();
    logic [31:0] got, exp;
    do_write(16'h0004, 32'h0000_0008);
    @(negedge clk); event_in[3] = 1'b1;
    repeat (5) @(negedge clk);
    event_in[3] = 1'b0;
    m_lat = m_lat | 8'h08;
    n_chk++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b want 1", irq); end
    do_read(16'h0003, got, exp);
    n_chk++; if (got !== exp) begin n_err++; $display("FAIL event_lat: got %h want %h", got, exp); end
    // W1C: latch clears on the strobe edge, irq follows one clock later
    @(negedge clk); addr = 16'h0003; data_mosi = 32'h08; data_mosi_rdy = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_lag: got %b want 1", irq); end
    @(negedge clk); data_mosi_rdy = 1'b0;
    m_wr++; m_lat = m_lat & ~8'h08;
    @(posedge clk); #1;
    n_chk++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b want 0", irq); end
    // preload bit 5, then line up a fresh edge with a W1C of the same bit
    @(negedge clk); event_in[5] = 1'b1;
    repeat (4) @(negedge clk); event_in[5] = 1'b0;
    repeat (4) @(negedge clk);
    m_lat = m_lat | 8'h20;
    event_in[5] = 1'b1;
    repeat (2) @(negedge clk);
    addr = 16'h0003; data_mosi = 32'h20; data_mosi_rdy = 1'b1;
    @(negedge clk); data_mosi_rdy = 1'b0; event_in[5] = 1'b0;
    m_wr++;
    do_read(16'h0003, got, exp);
    n_chk++; if (got !== exp) begin n_err++; $display("FAIL set_wins: got %h want %h", got, exp); end
    n_chk++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_masked: got %b want 0", irq); end
  endtask

  task automatic test_err_cnt();
    logic [31:0] got, exp;
    do_write(16'h0005, 32'h1);
    do_read(16'h00FF, got, exp);
    n_chk++; if (got !== exp) begin n_err++; $display("FAIL unmapped_read: got %h want %h", got, exp); end
    do_read(16'h0005, got, exp);
    n_chk++; if (got !== exp) begin n_err++; $display("FAIL err_one: got %h want %h", got, exp); end
    // hold the write strobe to an unmapped address long enough to saturate and wrap wr_cnt
    @(negedge clk); addr = 16'h0100; data_mosi = '0; data_mosi_rdy = 1'b1;
    repeat (65540) @(negedge clk);
    data_mosi_rdy = 1'b0;
    m_wr = m_wr + 16'(65540);
    m_err = 16'hFFFF;
    do_read(16'h0005, got, exp);
    n_chk++; if (got !== exp) begin n_err++; $display("FAIL err_sat: got %h want %h", got, exp); end
    do_read(16'h00FF, got, exp);
    do_read(16'h0005, got, exp);
    n_chk++; if (got !== exp) begin n_err++; $display("FAIL err_sat_hold: got %h want %h", got, exp); end
    do_read(16'h0006, got, exp);
    n_chk++; if (got !== exp) begin n_err++; $display("FAIL wr_cnt_wrap: got %h want %h", got, exp); end
    do_write(16'h0005, 32'h0);
    do_read(16'h0005, got, exp);
    n_chk++; if (got !== exp) begin n_err++; $display("FAIL err_clear: got %h want %h", got, exp); end
  endtask

  task automatic test_ctrl();
    logic [31:0] got, exp;
    do_write(16'h0010 + NC - 1, 32'h1234_5678);
    n_chk++; if (ctrl_out !== model_ctrl()) begin n_err++; $display("FAIL ctrl_top: got %h want %h", ctrl_out, model_ctrl()); end
    do_write(16'h0010 + NC, 32'hFFFF_FFFF);
    n_chk++; if (ctrl_out !== model_ctrl()) begin n_err++; $display("FAIL ctrl_oob: got %h want %h", ctrl_out, model_ctrl()); end
    do_read(16'h0005, got, exp);
    n_chk++; if (got !== exp) begin n_err++; $display("FAIL ctrl_oob_err: got %h want %h", got, exp); end
    do_write(16'h0010, 32'h0BAD_F00D);
    do_read(16'h0010 + NC - 1, got, exp);
    n_chk++; if (got !== exp) begin n_err++; $display("FAIL ctrl_read: got %h want %h", got, exp); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] got, exp;
    do_write(16'h0004, 32'h08);
    @(negedge clk); event_in[3] = 1'b1;
    repeat (5) @(negedge clk); event_in[3] = 1'b0;
    @(negedge clk); addr = 16'h0011; addr_rdy = 1'b1;
    @(negedge clk); #2 rst = 1'b1; #1;
    n_chk++; if (data_miso !== 32'd0 || ctrl_out !== '0 || irq !== 1'b0) begin
      n_err++; $display("FAIL midframe_rst: miso=%h irq=%b ctrl=%h want all 0", data_miso, irq, ctrl_out);
    end
    addr_rdy = 1'b0; data_mosi = 32'h5555_AAAA; data_mosi_rdy = 1'b1;
    @(negedge clk); data_mosi_rdy = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0; addr = 16'h0011; data_mosi = 32'hCAFE_F00D; data_mosi_rdy = 1'b1;
    @(negedge clk); data_mosi_rdy = 1'b0;
    m_wr++; m_ctrl[1] = 32'hCAFE_F00D;
    n_chk++; if (ctrl_out !== model_ctrl()) begin n_err++; $display("FAIL post_rst_write: got %h want %h", ctrl_out, model_ctrl()); end
    do_read(16'h0011, got, exp);
    n_chk++; if (got !== exp) begin n_err++; $display("FAIL post_rst_read: got %h want %h", got, exp); end
    do_read(16'h0006, got, exp);
    n_chk++; if (got !== exp) begin n_err++; $display("FAIL post_rst_trans: got %h want %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_scratch_status();
    test_event();
    test_err_cnt();
    test_ctrl();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
